// File: rtl/clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp and msip behind a single-beat bus slave.
// Optional macro CLINT_MTIP_OUT_EN adds a registered mtip output.
module clint #(
    parameter int DATA_SIZE             = 64,
    parameter int CLOCK_CYCLES_PER_TICK = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cyc,
    input  logic                 stb,
    input  logic                 we,
    input  logic [15:0]          addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 ack,
    output logic                 msip,
    output logic [63:0]          mtime,
    output logic [63:0]          mtimecmp
`ifdef CLINT_MTIP_OUT_EN
    ,
    output logic                 mtip
`endif
);

    localparam bit W64 = (DATA_SIZE == 64);
    localparam logic [15:0] AMASK = W64 ? 16'hFFF8 : 16'hFFFC;
    localparam int PW = (CLOCK_CYCLES_PER_TICK > 1) ?
                        $clog2(CLOCK_CYCLES_PER_TICK) : 1;
    localparam logic [PW-1:0] TC = PW'(CLOCK_CYCLES_PER_TICK - 1);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t state, state_n;

    logic          req;
    logic          wr;
    logic [15:0]   aw;
    logic [63:0]   wd;
    logic          sel_msip;
    logic          sel_cmp_lo;
    logic          sel_cmp_hi;
    logic          sel_time_lo;
    logic          sel_time_hi;
    logic          tick;
    logic [PW-1:0] prescale;
    logic [PW-1:0] prescale_n;
    logic [63:0]   mtime_n;
    logic [63:0]   mtimecmp_n;
    logic          msip_n;
    logic [DATA_SIZE-1:0] rd_mux;

    always_comb begin
        state_n = state;
        req     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cyc && stb) begin
                    req     = 1'b1;
                    state_n = ACK;
                end
            end
            ACK: state_n = IDLE;
        endcase
    end

    // Low address bits are masked, so the upper-half offsets only match in 32-bit mode
    assign aw          = addr & AMASK;
    assign wd          = 64'(wr_data);
    assign wr          = req && we;
    assign sel_msip    = (aw == 16'h0000);
    assign sel_cmp_lo  = (aw == 16'h4000);
    assign sel_cmp_hi  = (aw == 16'h4004);
    assign sel_time_lo = (aw == 16'hBFF8);
    assign sel_time_hi = (aw == 16'hBFFC);

    assign tick       = (prescale == TC);
    assign prescale_n = tick ? '0 : prescale + PW'(1);

    always_comb begin
        msip_n = msip;
        if (wr && sel_msip)
            msip_n = wd[0];
    end

    always_comb begin
        mtimecmp_n = mtimecmp;
        if (wr && sel_cmp_lo) begin
            mtimecmp_n[31:0] = wd[31:0];
            if (W64)
                mtimecmp_n[63:32] = wd[63:32];
        end
        if (wr && sel_cmp_hi)
            mtimecmp_n[63:32] = wd[31:0];
    end

    // A bus write to either half wins over the tick for the whole register
    always_comb begin
        mtime_n = mtime;
        if (wr && (sel_time_lo || sel_time_hi)) begin
            if (sel_time_lo) begin
                mtime_n[31:0] = wd[31:0];
                if (W64)
                    mtime_n[63:32] = wd[63:32];
            end
            if (sel_time_hi)
                mtime_n[63:32] = wd[31:0];
        end else if (tick) begin
            mtime_n = mtime + 64'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            sel_msip:    rd_mux = DATA_SIZE'({63'd0, msip});
            sel_cmp_lo:  rd_mux = W64 ? DATA_SIZE'(mtimecmp)
                                      : DATA_SIZE'({32'd0, mtimecmp[31:0]});
            sel_cmp_hi:  rd_mux = DATA_SIZE'({32'd0, mtimecmp[63:32]});
            sel_time_lo: rd_mux = W64 ? DATA_SIZE'(mtime)
                                      : DATA_SIZE'({32'd0, mtime[31:0]});
            sel_time_hi: rd_mux = DATA_SIZE'({32'd0, mtime[63:32]});
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack      <= 1'b0;
            rd_data  <= '0;
            msip     <= 1'b0;
            mtime    <= '0;
            mtimecmp <= '1;
            prescale <= '0;
        end else begin
            ack      <= req;
            rd_data  <= req ? rd_mux : '0;
            msip     <= msip_n;
            mtime    <= mtime_n;
            mtimecmp <= mtimecmp_n;
            prescale <= prescale_n;
        end
    end

`ifdef CLINT_MTIP_OUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            mtip <= 1'b0;
        else
            mtip <= (mtime_n >= mtimecmp_n);
    end
`endif

endmodule

// File: tb/tb_clint.sv
// Directed scoreboard bench for clint: a 64-bit/4-cycle-tick instance
// and a 32-bit/1-cycle-tick instance sharing clock and reset.
module tb_clint;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        c64, s64, w64;
    logic [15:0] a64;
    logic [63:0] wd64, rd64;
    logic        ack64, msip64;
    logic [63:0] mt64, mc64;

    logic        c32, s32, w32;
    logic [15:0] a32;
    logic [31:0] wd32, rd32;
    logic        ack32, msip32;
    logic [63:0] mt32, mc32;

`ifdef CLINT_MTIP_OUT_EN
    logic        mtip64, mtip32;
`endif

    int checks   = 0;
    int failures = 0;
    int edges;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];

    clint #(.DATA_SIZE(64), .CLOCK_CYCLES_PER_TICK(4)) u64 (
        .clock(clock), .reset(reset), .cyc(c64), .stb(s64), .we(w64),
        .addr(a64), .wr_data(wd64), .rd_data(rd64), .ack(ack64),
        .msip(msip64), .mtime(mt64), .mtimecmp(mc64)
`ifdef CLINT_MTIP_OUT_EN
        , .mtip(mtip64)
`endif
    );

    clint #(.DATA_SIZE(32), .CLOCK_CYCLES_PER_TICK(1)) u32 (
        .clock(clock), .reset(reset), .cyc(c32), .stb(s32), .we(w32),
        .addr(a32), .wr_data(wd32), .rd_data(rd32), .ack(ack32),
        .msip(msip32), .mtime(mt32), .mtimecmp(mc32)
`ifdef CLINT_MTIP_OUT_EN
        , .mtip(mtip32)
`endif
    );

    always #5 clock = ~clock;

    // Clock edges seen out of reset; equals the 1-cycle-tick mtime until it is written
    always @(posedge clock or posedge reset) begin
        if (reset)
            edges <= 0;
        else
            edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_req(input bit d32, input bit we, input logic [15:0] a,
                           input logic [63:0] wd, input logic [63:0] exp_rd,
                           input string tag);
        int   n;
        logic got;
        exp_t e;
        e.tag = tag;
        e.val = exp_rd;
        sb.push_back(e);
        if (d32) begin
            c32 = 1'b1; s32 = 1'b1; w32 = we; a32 = a; wd32 = wd[31:0];
        end else begin
            c64 = 1'b1; s64 = 1'b1; w64 = we; a64 = a; wd64 = wd;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 4) begin
            @(negedge clock);
            n++;
            got = d32 ? ack32 : ack64;
        end
        check({tag, " ack_latency"}, 64'(n), 64'd1);
        e = sb.pop_front();
        check({e.tag, " rd_data"}, d32 ? {32'd0, rd32} : rd64, e.val);
        if (d32) begin
            c32 = 1'b0; s32 = 1'b0; w32 = 1'b0;
        end else begin
            c64 = 1'b0; s64 = 1'b0; w64 = 1'b0;
        end
    endtask

    task automatic bus_end(input bit d32, input string tag);
        @(negedge clock);
        check({tag, " ack_drop"}, 64'(d32 ? ack32 : ack64), 64'd0);
        check({tag, " rd_idle"}, d32 ? {32'd0, rd32} : rd64, 64'd0);
    endtask

    initial begin
        int       e0;
        int       n;
        int       guard;
        logic     prev;
        c64 = 0; s64 = 0; w64 = 0; a64 = '0; wd64 = '0;
        c32 = 0; s32 = 0; w32 = 0; a32 = '0; wd32 = '0;

        repeat (2) @(negedge clock);
        check("rst_mtime", mt64, 64'd0);
        check("rst_mtimecmp", mc64, '1);
        check("rst_msip", 64'(msip64), 64'd0);
        check("rst_ack", 64'(ack64), 64'd0);
        check("rst_rd", rd64, 64'd0);

        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("free_mtime64", mt64, 64'd10);
        check("free_mtimecmp64", mc64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("free_msip64", 64'(msip64), 64'd0);
        check("free_mtime32", mt32, 64'd40);

        e0 = edges;
        bus_req(1, 1, 16'hBFFC, 64'h5, 64'd0, "t32_hi_wr");
        check("t32_hi_only", mt32, {32'd5, 32'(e0)});
        bus_end(1, "t32_hi_wr");
        bus_req(1, 1, 16'hBFF8, 64'hFFFF_FFFF, 64'(e0 + 1), "t32_lo_wr");
        check("t32_both", mt32, 64'h5_FFFF_FFFF);
        bus_end(1, "t32_lo_wr");
        check("t32_carry", mt32, 64'h6_0000_0000);

        bus_req(1, 1, 16'hBFFC, 64'hFFFF_FFFF, 64'd6, "wrap_hi");
        bus_end(1, "wrap_hi");
        bus_req(1, 1, 16'hBFF8, 64'hFFFF_FFFF, 64'd1, "wrap_lo");
        check("wrap_max", mt32, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_end(1, "wrap_lo");
        check("wrap_zero", mt32, 64'd0);

        bus_req(1, 1, 16'h4004, 64'h1234, 64'hFFFF_FFFF, "cmp32_hi_wr");
        bus_end(1, "cmp32_hi_wr");
        check("cmp32_half", mc32, 64'h0000_1234_FFFF_FFFF);
        bus_req(1, 0, 16'h4000, 64'd0, 64'hFFFF_FFFF, "cmp32_lo_rd");
        bus_end(1, "cmp32_lo_rd");
        bus_req(1, 0, 16'h4004, 64'd0, 64'h1234, "cmp32_hi_rd");
        bus_end(1, "cmp32_hi_rd");

        bus_req(0, 1, 16'h0000, 64'h1, 64'd0, "msip_set");
        check("msip_set_val", 64'(msip64), 64'd1);
        bus_end(0, "msip_set");
        bus_req(0, 1, 16'h0000, 64'hFFFF_FFFE, 64'd1, "msip_clr");
        check("msip_clr_val", 64'(msip64), 64'd0);
        bus_end(0, "msip_clr");
        bus_req(0, 0, 16'h0000, 64'd0, 64'd0, "msip_rd");
        bus_end(0, "msip_rd");

        bus_req(0, 1, 16'h4000, 64'h0123_4567_89AB_CDEF, '1, "cmp64_wr");
        bus_end(0, "cmp64_wr");
        check("cmp64_val", mc64, 64'h0123_4567_89AB_CDEF);
        bus_req(0, 0, 16'h4000, 64'd0, 64'h0123_4567_89AB_CDEF, "cmp64_rd");
        bus_end(0, "cmp64_rd");

        bus_req(0, 0, 16'h1234, 64'd0, 64'd0, "unmapped_rd");
        bus_end(0, "unmapped_rd");
        bus_req(0, 1, 16'h1234, '1, 64'd0, "unmapped_wr");
        bus_end(0, "unmapped_wr");
        check("unmapped_cmp", mc64, 64'h0123_4567_89AB_CDEF);
        check("unmapped_msip", 64'(msip64), 64'd0);

        guard = 0;
        while ((edges % 4) != 3 && guard < 8) begin
            @(negedge clock);
            guard++;
        end
        bus_req(0, 1, 16'hBFF8, 64'd100, 64'(edges / 4), "tc_wr");
        check("tc_no_inc", mt64, 64'd100);
        bus_end(0, "tc_wr");
        repeat (2) @(negedge clock);
        check("tc_hold", mt64, 64'd100);
        @(negedge clock);
        check("tc_next", mt64, 64'd101);

`ifdef CLINT_MTIP_OUT_EN
        bus_req(0, 1, 16'h4000, 64'd20, 64'h0123_4567_89AB_CDEF, "mtip_cmp");
        bus_end(0, "mtip_cmp");
        bus_req(0, 1, 16'hBFF8, 64'd18, 64'd101, "mtip_time");
        bus_end(0, "mtip_time");
        check("mtip_low", 64'(mtip64), 64'd0);
        n    = 0;
        prev = mtip64;
        while (mt64 != 64'd20 && n < 16) begin
            prev = mtip64;
            @(negedge clock);
            n++;
        end
        check("mtip_time20", mt64, 64'd20);
        check("mtip_rise", 64'(mtip64), 64'd1);
        check("mtip_prev", 64'(prev), 64'd0);
`endif

        bus_req(0, 1, 16'h0000, 64'h1, 64'd0, "rst_in_ack");
        reset = 1'b1;
        #1;
        check("rst_ack_drop", 64'(ack64), 64'd0);
        check("rst_ack_rd", rd64, 64'd0);
        check("rst_ack_msip", 64'(msip64), 64'd0);
        check("rst_ack_mtime", mt64, 64'd0);
        check("rst_ack_cmp", mc64, '1);
        check("rst_ack_mtime32", mt32, 64'd0);
`ifdef CLINT_MTIP_OUT_EN
        check("rst_ack_mtip", 64'(mtip64), 64'd0);
`endif
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
